// File: rtl/jt03_bus_writer.sv
// ---------------------------------------------------------------------------
// jt03_bus_writer
//
// Upstream bus master for the jt03 (YM2203) core. Write requests of the form
// {register, value} arrive on a valid/ready interface and are queued in a
// small FIFO. Each request is replayed as the chip's two-phase write:
//   address phase : addr=0, din=register, wr_n pulsed low
//   gap           : cs_n/wr_n high, din keeps the register number
//   data phase    : addr=1, din=value, wr_n pulsed low
//   recovery      : fixed wait (or status poll when the option is built in)
// All bus timing advances only on clock-enable ticks (cen=1). The FIFO
// accepts pushes on every clk regardless of cen.
//
// Build option:
//   JT03_BUSY_POLL_EN - when defined, the fixed recovery wait is replaced by
//   a status poll: cs_n=0, addr=0, rd_n=0 and chip_dout[7] is sampled each
//   cen tick. The bus returns to idle on the first tick with bit 7 clear,
//   but never before DATA_WAIT ticks. When undefined, rd_n is tied high and
//   chip_dout is ignored.
//
// Parameters:
//   FIFO_AW   - log2 of the request FIFO depth
//   WR_PULSE  - wr_n low time per phase, in cen ticks (>=1)
//   ADDR_WAIT - gap between address and data phase, in cen ticks (>=1)
//   DATA_WAIT - recovery after the data phase, in cen ticks (>=1)
//
// Ports:
//   clk        system clock (same as jt03 clk)
//   rst        asynchronous active-high reset
//   cen        clock enable shared with jt03
//   flush      synchronous FIFO clear
//   req_valid  request present
//   req_ready  FIFO can accept a request
//   req_reg    jt03 register number
//   req_val    value to write
//   chip_dout  jt03 status output (only used with JT03_BUSY_POLL_EN)
//   cs_n       jt03 chip select
//   wr_n       jt03 write strobe
//   rd_n       jt03 read strobe
//   addr       jt03 address line
//   din        jt03 data bus
//   busy       FIFO non-empty or a transaction in flight
//   level      FIFO occupancy
// ---------------------------------------------------------------------------
module jt03_bus_writer #(
   parameter int FIFO_AW   = 3,
   parameter int WR_PULSE  = 1,
   parameter int ADDR_WAIT = 2,
   parameter int DATA_WAIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cen,
   input  logic               flush,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [7:0]         req_reg,
   input  logic [7:0]         req_val,
   input  logic [7:0]         chip_dout,
   output logic               cs_n,
   output logic               wr_n,
   output logic               rd_n,
   output logic               addr,
   output logic [7:0]         din,
   output logic               busy,
   output logic [FIFO_AW:0]   level
);

   localparam int                 Depth     = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   FullLevel = Depth[FIFO_AW:0];
   localparam int                 TW        = 16;

`ifdef JT03_BUSY_POLL_EN
   typedef enum logic [2:0] {
      IDLE,
      A_WR,
      A_GAP,
      D_WR,
      POLL
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE,
      A_WR,
      A_GAP,
      D_WR,
      D_REC
   } state_t;
`endif

   // ------------------------------------------------------------------
   // Request FIFO storage and bookkeeping
   // ------------------------------------------------------------------
   logic [15:0]          mem_q [Depth];
   logic [FIFO_AW-1:0]   wptr_q;
   logic [FIFO_AW-1:0]   rptr_q;
   logic [FIFO_AW:0]     level_q;
   logic [FIFO_AW:0]     level_d;
   logic                 ready_q;
   logic                 push;
   logic                 pop;
   logic [15:0]          popData;

   // FSM registers and registered bus outputs
   state_t               state_q;
   logic [TW-1:0]        timer_q;
   logic [7:0]           val_q;
   logic                 cs_n_q;
   logic                 wr_n_q;
   logic                 addr_q;
   logic [7:0]           din_q;

   assign push    = req_valid && ready_q;
   // A flush cycle never starts a new transaction: the queue is being
   // discarded, so the head entry must not escape onto the bus.
   assign pop     = cen && (state_q == IDLE) && (level_q != '0) && !flush;
   assign popData = mem_q[rptr_q];

   // Next occupancy. Flush dominates, so a push in the same clk is dropped.
   // A simultaneous push and pop leaves the level unchanged.
   always_comb begin
      level_d = level_q;
      if (flush) begin
         level_d = '0;
      end else if (push && !pop) begin
         level_d = level_q + (FIFO_AW+1)'(1);
      end else if (pop && !push) begin
         level_d = level_q - (FIFO_AW+1)'(1);
      end
   end

   // Storage array has no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_q[wptr_q] <= {req_reg, req_val};
      end
   end

   // Pointers wrap naturally at 2^FIFO_AW. req_ready is registered from the
   // next occupancy so it is a clean flop output towards the source.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
         ready_q <= 1'b1;
      end else begin
         level_q <= level_d;
         ready_q <= (level_d != FullLevel);
         if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            if (push) begin
               wptr_q <= wptr_q + FIFO_AW'(1);
            end
            if (pop) begin
               rptr_q <= rptr_q + FIFO_AW'(1);
            end
         end
      end
   end

`ifdef JT03_BUSY_POLL_EN
   logic rd_n_q;
`else
   logic unusedChipDout;
   assign unusedChipDout = ^chip_dout;
`endif

   // ------------------------------------------------------------------
   // Bus sequencer. Each state's timer is loaded with (ticks-1) on entry
   // and the state is left on the tick where the timer reads zero, so a
   // phase lasts exactly its parameter in cen ticks. Outputs are set on
   // the transition into a state, which keeps addr/din stable for the whole
   // wr_n-low window.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         timer_q <= '0;
         val_q   <= '0;
         cs_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         addr_q  <= 1'b0;
         din_q   <= '0;
`ifdef JT03_BUSY_POLL_EN
         rd_n_q  <= 1'b1;
`endif
      end else if (cen) begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  val_q   <= popData[7:0];
                  din_q   <= popData[15:8];
                  addr_q  <= 1'b0;
                  cs_n_q  <= 1'b0;
                  wr_n_q  <= 1'b0;
                  timer_q <= TW'(WR_PULSE - 1);
                  state_q <= A_WR;
               end
            end
            A_WR: begin
               if (timer_q == '0) begin
                  cs_n_q  <= 1'b1;
                  wr_n_q  <= 1'b1;
                  timer_q <= TW'(ADDR_WAIT - 1);
                  state_q <= A_GAP;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            A_GAP: begin
               if (timer_q == '0) begin
                  cs_n_q  <= 1'b0;
                  wr_n_q  <= 1'b0;
                  addr_q  <= 1'b1;
                  din_q   <= val_q;
                  timer_q <= TW'(WR_PULSE - 1);
                  state_q <= D_WR;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
            D_WR: begin
               if (timer_q == '0) begin
                  wr_n_q  <= 1'b1;
                  addr_q  <= 1'b0;
                  timer_q <= TW'(DATA_WAIT - 1);
`ifdef JT03_BUSY_POLL_EN
                  // Chip stays selected: the poll reads the status register.
                  rd_n_q  <= 1'b0;
                  state_q <= POLL;
`else
                  cs_n_q  <= 1'b1;
                  state_q <= D_REC;
`endif
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
`ifdef JT03_BUSY_POLL_EN
            POLL: begin
               // Minimum dwell first, then wait for the busy flag to clear.
               if (timer_q != '0) begin
                  timer_q <= timer_q - TW'(1);
               end else if (!chip_dout[7]) begin
                  cs_n_q  <= 1'b1;
                  rd_n_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
`else
            D_REC: begin
               if (timer_q == '0) begin
                  state_q <= IDLE;
               end else begin
                  timer_q <= timer_q - TW'(1);
               end
            end
`endif
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = ready_q;
   assign cs_n      = cs_n_q;
   assign wr_n      = wr_n_q;
   assign addr      = addr_q;
   assign din       = din_q;
   assign level     = level_q;
   assign busy      = (state_q != IDLE) || (level_q != '0);
`ifdef JT03_BUSY_POLL_EN
   assign rd_n      = rd_n_q;
`else
   assign rd_n      = 1'b1;
`endif

endmodule

// File: tb/tb_jt03_bus_writer.sv
// ---------------------------------------------------------------------------
// tb_jt03_bus_writer
//
// Directed self-checking bench for jt03_bus_writer (default parameters:
// FIFO_AW=3, WR_PULSE=1, ADDR_WAIT=2, DATA_WAIT=4). Inputs change and
// outputs are sampled 1 ns after each rising clk edge.
// ---------------------------------------------------------------------------
module tb_jt03_bus_writer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cen;
   logic       flush;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] req_reg;
   logic [7:0] req_val;
   logic [7:0] chip_dout;
   logic       cs_n;
   logic       wr_n;
   logic       rd_n;
   logic       addr;
   logic [7:0] din;
   logic       busy;
   logic [3:0] level;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jt03_bus_writer dut (
      .clk       (clk),
      .rst       (rst),
      .cen       (cen),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_reg   (req_reg),
      .req_val   (req_val),
      .chip_dout (chip_dout),
      .cs_n      (cs_n),
      .wr_n      (wr_n),
      .rd_n      (rd_n),
      .addr      (addr),
      .din       (din),
      .busy      (busy),
      .level     (level)
   );

   // Every comparison goes through here so the counters stay consistent.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n clk edges and settle 1 ns past the last one.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present one request for a single clk; the caller ensures req_ready=1.
   task automatic applyStimulus(input logic [7:0] r, input logic [7:0] v);
      req_reg   = r;
      req_val   = v;
      req_valid = 1'b1;
      tick(1);
      req_valid = 1'b0;
   endtask

   initial begin : main
      int   aCyc [3];
      int   aDin [3];
      int   aLvl [3];
      int   nA;
      int   nD;
      int   dDin;
      int   order [9];
      logic prevWr;
      logic prevAddr;
      logic prevBusy;
      logic pushNow;
      int   aFall, aRise, dFall, dRise, busyFall, viol;
      logic [10:0] snap;

      rst       = 1'b1;
      cen       = 1'b1;
      flush     = 1'b0;
      req_valid = 1'b0;
      req_reg   = '0;
      req_val   = '0;
      chip_dout = '0;

      // ---------------- reset state ----------------
      #2;
      checkOutput("rst_cs_n", cs_n, 1);
      checkOutput("rst_wr_n", wr_n, 1);
      checkOutput("rst_rd_n", rd_n, 1);
      checkOutput("rst_addr", addr, 0);
      checkOutput("rst_din", din, 0);
      checkOutput("rst_ready", req_ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_level", level, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      tick(1);

      // ---------------- single write {07,38} ----------------
      $display("[TB] single write");
      applyStimulus(8'h07, 8'h38);
      checkOutput("t1_level_push", level, 1);
      checkOutput("t1_busy_push", busy, 1);
      checkOutput("t1_wr_idle", wr_n, 1);
      tick(1);
      checkOutput("t1_a_wr_n", wr_n, 0);
      checkOutput("t1_a_cs_n", cs_n, 0);
      checkOutput("t1_a_addr", addr, 0);
      checkOutput("t1_a_din", din, 8'h07);
      checkOutput("t1_level_pop", level, 0);
      tick(1);
      checkOutput("t1_gap1_wr_n", wr_n, 1);
      checkOutput("t1_gap1_cs_n", cs_n, 1);
      checkOutput("t1_gap1_din", din, 8'h07);
      tick(1);
      checkOutput("t1_gap2_wr_n", wr_n, 1);
      tick(1);
      checkOutput("t1_d_wr_n", wr_n, 0);
      checkOutput("t1_d_cs_n", cs_n, 0);
      checkOutput("t1_d_addr", addr, 1);
      checkOutput("t1_d_din", din, 8'h38);
      tick(1);
      checkOutput("t1_rec_wr_n", wr_n, 1);
      checkOutput("t1_rec_addr", addr, 0);
      checkOutput("t1_rec_busy", busy, 1);
      tick(3);
      checkOutput("t1_rec_end_busy", busy, 1);
      // Busy drops on the 9th clk after the push edge (8th after the pop).
      tick(1);
      checkOutput("t1_done_busy", busy, 0);
      checkOutput("t1_done_cs_n", cs_n, 1);

      // ---------------- three queued requests ----------------
      $display("[TB] back-to-back requests");
      cen = 1'b0;
      applyStimulus(8'h07, 8'h38);
      applyStimulus(8'h01, 8'h01);
      applyStimulus(8'h08, 8'h0F);
      checkOutput("t2_level_queued", level, 3);
      checkOutput("t2_frozen_wr_n", wr_n, 1);
      cen = 1'b1;
      nA = 0;
      for (int i = 0; i < 3; i++) begin
         aCyc[i] = -1;
         aDin[i] = -1;
         aLvl[i] = -1;
      end
      prevWr = wr_n;
      for (int c = 0; c < 40; c++) begin
         tick(1);
         if (prevWr && !wr_n && !addr && nA < 3) begin
            aCyc[nA] = c;
            aDin[nA] = int'(din);
            aLvl[nA] = int'(level);
            nA++;
         end
         prevWr = wr_n;
      end
      checkOutput("t2_strobe_count", nA, 3);
      checkOutput("t2_pitch01", aCyc[1] - aCyc[0], 9);
      checkOutput("t2_pitch12", aCyc[2] - aCyc[1], 9);
      checkOutput("t2_din0", aDin[0], 8'h07);
      checkOutput("t2_din1", aDin[1], 8'h01);
      checkOutput("t2_din2", aDin[2], 8'h08);
      checkOutput("t2_lvl0", aLvl[0], 2);
      checkOutput("t2_lvl1", aLvl[1], 1);
      checkOutput("t2_lvl2", aLvl[2], 0);
      checkOutput("t2_busy_end", busy, 0);

      // ---------------- fill to full with cen=0 ----------------
      $display("[TB] fill FIFO while cen=0");
      cen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(8'(8'h10 + i), 8'(8'h20 + i));
      end
      checkOutput("t3_ready_full", req_ready, 0);
      checkOutput("t3_level_full", level, 8);
      req_reg   = 8'h18;
      req_val   = 8'h28;
      req_valid = 1'b1;
      tick(2);
      checkOutput("t3_level_held", level, 8);
      checkOutput("t3_ready_held", req_ready, 0);
      cen = 1'b1;
      nA = 0;
      for (int i = 0; i < 9; i++) begin
         order[i] = -1;
      end
      prevWr = wr_n;
      for (int c = 0; c < 120; c++) begin
         pushNow = req_valid && req_ready;
         tick(1);
         if (pushNow) begin
            req_valid = 1'b0;
         end
         if (prevWr && !wr_n && !addr && nA < 9) begin
            order[nA] = int'(din);
            nA++;
         end
         prevWr = wr_n;
      end
      checkOutput("t3_strobe_count", nA, 9);
      for (int i = 0; i < 9; i++) begin
         checkOutput($sformatf("t3_order%0d", i), order[i], 32'(8'h10 + i));
      end
      checkOutput("t3_level_end", level, 0);
      checkOutput("t3_busy_end", busy, 0);

      // ---------------- cen one clk in four ----------------
      $display("[TB] cen 1-in-4");
      cen = 1'b0;
      applyStimulus(8'h05, 8'hAA);
      aFall = -1; aRise = -1; dFall = -1; dRise = -1; busyFall = -1;
      viol = 0;
      prevWr = wr_n;
      prevAddr = addr;
      prevBusy = busy;
      for (int i = 0; i < 60; i++) begin
         cen  = (i % 4 == 0);
         snap = {cs_n, wr_n, addr, din};
         tick(1);
         if (!cen && snap != {cs_n, wr_n, addr, din}) begin
            viol++;
         end
         if (prevWr && !wr_n) begin
            if (!addr) aFall = i;
            else       dFall = i;
         end
         if (!prevWr && wr_n) begin
            if (!prevAddr) aRise = i;
            else           dRise = i;
         end
         if (prevBusy && !busy) begin
            busyFall = i;
         end
         prevWr   = wr_n;
         prevAddr = addr;
         prevBusy = busy;
      end
      checkOutput("t4_a_fall", aFall, 0);
      checkOutput("t4_a_rise", aRise, 4);
      checkOutput("t4_d_fall", dFall, 12);
      checkOutput("t4_d_rise", dRise, 16);
      checkOutput("t4_busy_fall", busyFall, 32);
      checkOutput("t4_hold_viol", viol, 0);
      cen = 1'b1;

      // ---------------- reset during data phase ----------------
      $display("[TB] reset mid-transaction");
      applyStimulus(8'h0A, 8'h00);
      applyStimulus(8'h0B, 8'h11);
      checkOutput("t5_a_wr_n", wr_n, 0);
      checkOutput("t5_a_din", din, 8'h0A);
      tick(3);
      checkOutput("t5_d_wr_n", wr_n, 0);
      checkOutput("t5_d_addr", addr, 1);
      checkOutput("t5_level_pre", level, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t5_rst_cs_n", cs_n, 1);
      checkOutput("t5_rst_wr_n", wr_n, 1);
      checkOutput("t5_rst_level", level, 0);
      checkOutput("t5_rst_addr", addr, 0);
      checkOutput("t5_rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      nA = 0;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         if (!wr_n) nA++;
      end
      checkOutput("t5_no_strobes", nA, 0);
      checkOutput("t5_level_after", level, 0);

      // ---------------- flush during address gap ----------------
      $display("[TB] flush during address gap");
      cen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(8'(8'h31 + i), 8'(8'h41 + i));
      end
      checkOutput("t6_level_queued", level, 6);
      cen = 1'b1;
      tick(1);
      checkOutput("t6_a_din", din, 8'h31);
      checkOutput("t6_level_pop", level, 5);
      tick(1);
      checkOutput("t6_gap_wr_n", wr_n, 1);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      checkOutput("t6_level_flushed", level, 0);
      checkOutput("t6_ready_flushed", req_ready, 1);
      nA = 0;
      nD = 0;
      dDin = -1;
      prevWr = wr_n;
      for (int c = 0; c < 30; c++) begin
         tick(1);
         if (prevWr && !wr_n) begin
            if (addr) begin
               nD++;
               dDin = int'(din);
            end else begin
               nA++;
            end
         end
         prevWr = wr_n;
      end
      checkOutput("t6_d_count", nD, 1);
      checkOutput("t6_d_din", dDin, 8'h41);
      checkOutput("t6_a_count", nA, 0);
      checkOutput("t6_busy_end", busy, 0);
      checkOutput("t6_level_end", level, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
